// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_e          : fetch FSM states, also exported on the debug port
//   RESP_OKAY        : AXI-lite OKAY read response code
//   NOP_INSTR        : addi x0,x0,0, substituted when a fetch times out
//   DEFAULT_RESET_PC : boot PC, shared with the core top
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_AR      = 2'd0,
    ST_R_WAIT  = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT_PC = 2'd3
  } state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one non-speculative instruction in flight.
// Issues a single-beat read on the AR/R port, hands the word and its PC to
// decode, then waits for decode to redirect the PC before fetching again.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   pc_next           : next PC from decode
//   pc_write_enable   : one-cycle strobe, load pc_next and start next fetch
//   ifu_send_valid/ifu_send_ready, instruction, pc : handoff to decode
//   fetch_err         : sticky, bad rresp or R-channel timeout seen
//   fetch_cnt         : instructions handed to decode (wraps)
//   araddr/arvalid/arready, rdata/rresp/rvalid/rready : memory read port
//   dbg_state_o       : current FSM state, for observation only
//
// Handshakes (AR, R and decode handoff) all use valid/ready: a transfer
// happens on a clock edge where both are high; a raised valid and its
// payload stay stable until that transfer.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        pc_write_enable,
  input  logic        ifu_send_ready,
  output logic        ifu_send_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output state_e      dbg_state_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e         state_q;
  logic [31:0]    pc_q;
  logic [31:0]    instr_q;
  logic [31:0]    cnt_q;
  logic [31:0]    cnt_d;
  logic [TW-1:0]  tmo_q;
  logic [TW-1:0]  tmo_d;
  logic           arvalid_q;
  logic           rready_q;
  logic           send_valid_q;
  logic           err_q;

  assign tmo_d = tmo_q + TW'(1);
  assign cnt_d = cnt_q + 32'd1;

  // Handshake outputs are registered and set alongside the state they
  // belong to, so they are all low while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_AR;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      send_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_AR: begin
          arvalid_q <= 1'b1;
          if (arvalid_q && arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            tmo_q     <= '0;
            state_q   <= ST_R_WAIT;
          end
        end
        ST_R_WAIT: begin
          tmo_q <= tmo_d;
          if (rvalid && rready_q) begin
            instr_q      <= rdata;
            if (rresp != RESP_OKAY) err_q <= 1'b1;
            rready_q     <= 1'b0;
            send_valid_q <= 1'b1;
            state_q      <= ST_SEND;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            // Abandon the fetch; decode gets a harmless nop.
            instr_q      <= NOP_INSTR;
            err_q        <= 1'b1;
            rready_q     <= 1'b0;
            send_valid_q <= 1'b1;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (send_valid_q && ifu_send_ready) begin
            cnt_q        <= cnt_d;
            send_valid_q <= 1'b0;
            // A redirect coinciding with the handoff skips WAIT_PC.
            if (pc_write_enable) begin
              pc_q      <= pc_next;
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end else begin
              state_q   <= ST_WAIT_PC;
            end
          end
        end
        ST_WAIT_PC: begin
          if (pc_write_enable) begin
            pc_q      <= pc_next;
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        default: state_q <= ST_AR;
      endcase
    end
  end

  assign araddr         = pc_q;
  assign pc             = pc_q;
  assign arvalid        = arvalid_q;
  assign rready         = rready_q;
  assign ifu_send_valid = send_valid_q;
  assign instruction    = instr_q;
  assign fetch_err      = err_q;
  assign fetch_cnt      = cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. The memory side is driven step by step;
// each read response pushes the expected {pc, instruction} into a queue,
// and each decode handoff pops and compares it.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pc_next = '0;
  logic        pc_write_enable = 1'b0;
  logic        ifu_send_ready = 1'b0;
  logic        ifu_send_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  state_e      dbg_state;

  ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .pc_next(pc_next), .pc_write_enable(pc_write_enable),
    .ifu_send_ready(ifu_send_ready), .ifu_send_valid(ifu_send_valid),
    .instruction(instruction), .pc(pc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A redirect while a fetch is in progress is a decode-side protocol bug.
  always @(posedge clk) begin
    if (!rst && pc_write_enable && (dbg_state == ST_AR || dbg_state == ST_R_WAIT)) begin
      bad++;
      $error("FAIL pwe_in_fetch observed=%0d expected=none", dbg_state);
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for arvalid, optionally stall it, then accept it.
  task automatic do_ar(input logic [31:0] exp_addr, input int stall);
    int n = 0;
    while (arvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_seen", {31'd0, arvalid}, 32'd1);
    check("araddr", araddr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      check("ar_hold_addr", araddr, exp_addr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("rready_on", {31'd0, rready}, 32'd1);
    check("arvalid_off", {31'd0, arvalid}, 32'd0);
  endtask

  // Return a read beat after 'delay' cycles in R_WAIT.
  task automatic do_r(input logic [31:0] data, input logic [1:0] resp,
                      input logic [31:0] exp_pc, input int delay);
    exp_q.push_back({exp_pc, data});
    for (int i = 0; i < delay; i++) begin
      check("rwait_rready", {31'd0, rready}, 32'd1);
      check("rwait_no_send", {31'd0, ifu_send_valid}, 32'd0);
      @(negedge clk);
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
    if (resp != RESP_OKAY) exp_err = 1'b1;
    check("send_valid_on", {31'd0, ifu_send_valid}, 32'd1);
    check("rready_off", {31'd0, rready}, 32'd0);
  endtask

  // Hold decode off for 'stall' cycles, then take the instruction,
  // optionally issuing a redirect in the same cycle.
  task automatic do_send(input int stall, input logic pwe, input logic [31:0] pcn);
    logic [63:0] e;
    for (int i = 0; i < stall; i++) begin
      ifu_send_ready = 1'b0;
      check("bp_valid", {31'd0, ifu_send_valid}, 32'd1);
      if (exp_q.size() > 0) begin
        check("bp_instr", instruction, exp_q[0][31:0]);
        check("bp_pc", pc, exp_q[0][63:32]);
      end
      check("bp_cnt", fetch_cnt, exp_cnt);
      @(negedge clk);
    end
    check("send_valid", {31'd0, ifu_send_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("send_instr", instruction, e[31:0]);
      check("send_pc", pc, e[63:32]);
    end
    ifu_send_ready  = 1'b1;
    pc_write_enable = pwe;
    pc_next         = pcn;
    exp_cnt         = exp_cnt + 32'd1;
    @(negedge clk);
    ifu_send_ready  = 1'b0;
    pc_write_enable = 1'b0;
    check("send_valid_off", {31'd0, ifu_send_valid}, 32'd0);
    check("fetch_cnt", fetch_cnt, exp_cnt);
    check("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
    if (pwe) begin
      check("skip_arvalid", {31'd0, arvalid}, 32'd1);
      check("skip_araddr", araddr, pcn);
      check("skip_state", {30'd0, dbg_state}, {30'd0, ST_AR});
    end
  endtask

  task automatic pulse_pc(input int gap, input logic [31:0] pcn);
    repeat (gap) @(negedge clk);
    pc_next         = pcn;
    pc_write_enable = 1'b1;
    @(negedge clk);
    pc_write_enable = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_send_valid", {31'd0, ifu_send_valid}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_arvalid", {31'd0, arvalid}, 32'd1);

    // Zero-wait fetch from reset PC.
    do_ar(32'h8000_0000, 0);
    do_r(32'h0010_0073, RESP_OKAY, 32'h8000_0000, 0);
    do_send(0, 1'b0, 32'd0);

    // Redirect two cycles after handoff; AR stall and decode backpressure.
    check("wait_pc_idle", {31'd0, arvalid}, 32'd0);
    pulse_pc(1, 32'h8000_0010);
    do_ar(32'h8000_0010, 2);
    do_r(32'h0000_0513, RESP_OKAY, 32'h8000_0010, 3);
    do_send(5, 1'b0, 32'd0);

    // SLVERR response sets the sticky error.
    pulse_pc(0, 32'h8000_0020);
    do_ar(32'h8000_0020, 0);
    do_r(32'hdead_beef, 2'b10, 32'h8000_0020, 1);
    check("err_set", {31'd0, fetch_err}, 32'd1);
    do_send(0, 1'b0, 32'd0);

    // OKAY fetch keeps the error; redirect issued with the handoff.
    pulse_pc(2, 32'h8000_0024);
    do_ar(32'h8000_0024, 0);
    do_r(32'h0020_0093, RESP_OKAY, 32'h8000_0024, 0);
    do_send(1, 1'b1, 32'h8000_0004);

    // Fetch from the skipped-WAIT_PC redirect, unaligned PC next.
    do_ar(32'h8000_0004, 0);
    do_r(32'h0030_0113, RESP_OKAY, 32'h8000_0004, 0);
    do_send(0, 1'b0, 32'd0);
    pulse_pc(0, 32'h8000_0032);

    // Timeout: rvalid never comes.
    do_ar(32'h8000_0032, 0);
    exp_q.push_back({32'h8000_0032, NOP_INSTR});
    exp_err = 1'b1;
    n = 0;
    while (rready === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_cycles", n, 32'd8);
    check("tmo_send_valid", {31'd0, ifu_send_valid}, 32'd1);
    check("tmo_err", {31'd0, fetch_err}, 32'd1);
    do_send(0, 1'b0, 32'd0);

    // Reset in R_WAIT, then a stray late read beat.
    pulse_pc(0, 32'h8000_0040);
    do_ar(32'h8000_0040, 0);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    check("rr_rready", {31'd0, rready}, 32'd0);
    check("rr_instr", instruction, 32'd0);
    check("rr_send_valid", {31'd0, ifu_send_valid}, 32'd0);
    check("rr_cnt", fetch_cnt, 32'd0);
    check("rr_err", {31'd0, fetch_err}, 32'd0);
    do_ar(32'h8000_0000, 0);
    do_r(32'h0010_0073, RESP_OKAY, 32'h8000_0000, 0);
    do_send(0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit at the front of the multicycle core.
- Issues single-beat instruction reads on an AXI-lite-style AR/R read port.
- Presents each fetched instruction and its PC to the decode stage through a valid/ready handshake.
- After each handoff, waits for the decode stage's PC redirect (pc_next with pc_write_enable) before fetching again. There is no speculation: exactly one instruction is in flight.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- TIMEOUT, 1024, maximum cycles spent in R_WAIT before a fetch is abandoned as an error.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- pc_next  input  32  next PC from decode
- pc_write_enable  input  1  one-cycle strobe: load pc_next and fetch
- ifu_send_ready  input  1  decode stage ready to accept
- ifu_send_valid  output  1  instruction/pc valid to decode
- instruction  output  32  fetched instruction word
- pc  output  32  PC of instruction
- fetch_err  output  1  sticky: bad rresp or timeout seen
- fetch_cnt  output  32  count of instructions handed to decode
- araddr  output  32  read address
- arvalid  output  1  read address valid
- arready  input  1  read address ready
- rdata  input  32  read data
- rresp  input  2  read response; 2'b00 = OKAY
- rvalid  input  1  read data valid
- rready  output  1  read data ready

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values:
  - pc_r = RESET_PC, state = AR.
  - arvalid = 0, rready = 0, ifu_send_valid = 0.
  - instruction = 0, fetch_err = 0, fetch_cnt = 0.
  - The first arvalid asserts in the cycle after rst deasserts.
- States: AR, R_WAIT, SEND, WAIT_PC.
- AR:
  - arvalid = 1, araddr = pc_r.
  - On arvalid && arready, go to R_WAIT.
  - araddr is held stable while arvalid is high and not accepted.
- R_WAIT:
  - rready = 1; the timeout counter increments each cycle.
  - On rvalid: latch rdata into instruction and go to SEND.
  - If rresp != 0 at that beat, set fetch_err.
  - If the counter reaches TIMEOUT-1 without rvalid: set fetch_err, latch instruction = 32'h0000_0013 (nop), go to SEND.
  - The counter clears on every entry to R_WAIT.
- SEND:
  - ifu_send_valid = 1.
  - instruction and pc are stable until transfer.
  - On ifu_send_valid && ifu_send_ready: fetch_cnt increments (wraps at 2^32), go to WAIT_PC, and ifu_send_valid drops the next cycle.
- WAIT_PC:
  - On pc_write_enable: pc_r = pc_next, go to AR.
- pc_write_enable timing:
  - It is honoured only in SEND and in WAIT_PC.
  - If it arrives in SEND in the same cycle as the handoff, pc_r is loaded and the next state is AR directly (WAIT_PC is skipped).
  - If it arrives in SEND without a handoff, it is ignored.
  - In AR and R_WAIT it is ignored; a bench assertion flags it.
- pc_next handling:
  - pc_next is not checked for alignment.
  - araddr = pc_next exactly, with no masking.
- Response-side rules:
  - An rvalid beat outside R_WAIT is ignored: rready = 0, nothing is latched.
  - arready outside AR has no effect.
- fetch_err clears only on rst.
- Reset mid-fetch: all state returns to the reset values in the next cycle. An outstanding memory response arriving later is discarded, since rready = 0 until R_WAIT.
- Latency, zero-wait memory: AR accept at cycle N, rvalid at N+1, ifu_send_valid at N+2.

Decomposition:
- Shared package holds:
  - State enum {AR, R_WAIT, SEND, WAIT_PC}.
  - RESP_OKAY = 2'b00.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC constant, shared with the core top.
- No sub-module. A single FSM plus counters is natural at this size.

Test Plan:
- Reset release, memory with arready=1 and 1-cycle rvalid, rdata=32'h00100073, ifu_send_ready=1 -> araddr=32'h8000_0000, then ifu_send_valid with instruction=32'h00100073, pc=32'h8000_0000, fetch_cnt=1.
- Handoff followed two cycles later by a pc_write_enable pulse with pc_next=32'h8000_0010 -> next arvalid has araddr=32'h8000_0010; the next handoff carries pc=32'h8000_0010.
- Backpressure: hold ifu_send_ready=0 for 5 cycles, then 1 -> ifu_send_valid stays high, instruction/pc unchanged, fetch_cnt increments once.
- Error paths:
  - rresp=2'b10 -> fetch_err=1 and stays 1 after later OKAY fetches.
  - Separately, TIMEOUT=8 with rvalid never asserted -> ifu_send_valid after 8 R_WAIT cycles with instruction=32'h00000013, fetch_err=1.
- Same-cycle handoff and pc_write_enable (pc_next=32'h8000_0004) -> arvalid the next cycle at 32'h8000_0004, no WAIT_PC cycle. Also: rst pulse while in R_WAIT, followed by a stray rvalid -> stray rvalid not latched; fetch restarts at 32'h8000_0000 with fetch_cnt=0.
